// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder:
// funct3 sizes, MMIO register offsets and STATUS bit positions.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] OFF_GPIO   = 4'h0;
  localparam logic [3:0] OFF_CYC_LO = 4'h4;
  localparam logic [3:0] OFF_CYC_HI = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int ST_MIS = 0;
  localparam int ST_ILL = 1;

endpackage

// File: rtl/dmem_responder_lsu_align.sv
// Lane handling between the core and the word RAM.
// Ports: i_funct3/i_addr_lo/i_wdata/i_rword in;
//        o_be, o_wdata (lane-replicated), o_rdata (extended),
//        o_illegal, o_misaligned, o_word out.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_illegal,
  output logic        o_misaligned,
  output logic        o_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16]
                               : i_rword[15:0];

  always_comb begin
    o_be         = '0;
    o_wdata      = '0;
    o_rdata      = '0;
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    o_word       = 1'b0;
    unique case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_funct3[2] ? {24'b0, w_byte}
                              : {{24{w_byte[7]}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_misaligned = i_addr_lo[0];
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_funct3[2] ? {16'b0, w_half}
                              : {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        o_misaligned = |i_addr_lo;
        o_be    = 4'hF;
        o_wdata = i_wdata;
        o_rdata = i_rword;
        o_word  = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
    // A misaligned access must neither write nor return lane data.
    if (o_misaligned) begin
      o_be    = '0;
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte lanes plus MMIO window
// (GPIO, 64-bit cycle counter, sticky STATUS).
// Ports: clk, reset (sync, high); MemWriteM, Mem_WrAddrM, Mem_WrDataM,
//        funct3M in; ReadDataM (combinational), gpio_out, err_irq out.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] Mem_WrAddrM,
  input  logic [31:0] Mem_WrDataM,
  input  logic [2:0]  funct3M,
  output logic [31:0] ReadDataM,
  output logic [31:0] gpio_out,
  output logic        err_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_gpio;
  logic [63:0] r_cycle;
  logic [1:0]  r_status;

  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_wdata;
  logic [31:0]   w_lsu_rdata;
  logic          w_illegal;
  logic          w_mis;
  logic          w_word;
  logic          w_bad;
  logic          w_mmio;
  logic [3:0]    w_off;
  logic          w_ram_we;
  logic          w_mmio_we;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;
  logic [31:0]   w_mmio_rdata;
  logic [31:0]   w_rdata;

  assign w_idx   = Mem_WrAddrM[AW+1:2];
  assign w_rword = r_mem[w_idx];
  assign w_mmio  = Mem_WrAddrM[31:4] == MMIO_BASE[31:4];
  assign w_off   = {Mem_WrAddrM[3:2], 2'b00};

  lsu_align u_align (
    .i_funct3     (funct3M),
    .i_addr_lo    (Mem_WrAddrM[1:0]),
    .i_wdata      (Mem_WrDataM),
    .i_rword      (w_rword),
    .o_be         (w_be),
    .o_wdata      (w_lane_wdata),
    .o_rdata      (w_lsu_rdata),
    .o_illegal    (w_illegal),
    .o_misaligned (w_mis),
    .o_word       (w_word)
  );

  assign w_bad     = w_illegal | w_mis;
  assign w_ram_we  = MemWriteM & ~reset & ~w_bad & ~w_mmio;
  assign w_mmio_we = MemWriteM & w_mmio & ~w_bad & w_word;

  // Sub-word MMIO stores are flagged like illegal funct3.
  assign w_set[ST_MIS] = MemWriteM & w_mis;
  assign w_set[ST_ILL] = MemWriteM &
                         (w_illegal | (w_mmio & ~w_mis & ~w_word));

  assign w_clr = (w_mmio_we && w_off == OFF_STATUS)
               ? Mem_WrDataM[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_lane_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio   <= '0;
      r_cycle  <= '0;
      r_status <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_mmio_we && w_off == OFF_GPIO) begin
        r_gpio <= Mem_WrDataM;
      end
      // A new error overrides a clear of the same bit.
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  always_comb begin
    w_mmio_rdata = '0;
    case (w_off)
      OFF_GPIO:   w_mmio_rdata = r_gpio;
      OFF_CYC_LO: w_mmio_rdata = r_cycle[31:0];
      OFF_CYC_HI: w_mmio_rdata = r_cycle[63:32];
      OFF_STATUS: w_mmio_rdata = {30'b0, r_status};
      default:    w_mmio_rdata = '0;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_bad:            w_rdata = '0;
      w_mmio & ~w_bad:  w_rdata = w_mmio_rdata;
      default:          w_rdata = w_lsu_rdata;
    endcase
  end

  assign ReadDataM = w_rdata;
  assign gpio_out  = r_gpio;
  assign err_irq   = |r_status;

endmodule
